// File: rtl/data_mem_lsu.sv
// data_mem_lsu: valid/ready load/store unit in front of a synchronous-read, byte-lane word RAM.
// Optional: define DATA_MEM_BOUNDS_CHECK_EN to fault word indices >= MEM_SIZE instead of wrapping.
module data_mem_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int unsigned IdxW  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int unsigned WordW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rword_q, rword_d;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic                  req_err, req_oob;
  logic [IdxW-1:0]       mem_idx;
  logic                  mem_we;
  logic [3:0]            wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [DATA_WIDTH-1:0] load_data;

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  assign req_oob = {2'b00, req_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_SIZE);
`else
  assign req_oob = 1'b0;
`endif

  // Alignment and funct3 legality, judged on the live request so err_q is ready by ACCESS.
  always_comb begin
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = |req_addr[1:0];
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
    req_err = req_err | req_oob;
  end

  // Out-of-range indices only reach the RAM when bounds checking is off, where they wrap.
  assign mem_idx = IdxW'(addr_q[ADDR_WIDTH-1:2] % WordW'(MEM_SIZE));

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
  end

  assign mem_we = (state_q == StAccess) && we_q && !err_q && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[mem_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    lane_byte = rword_q[8*addr_q[1:0] +: 8];
    lane_half = rword_q[16*addr_q[1] +: 16];
    case (funct3_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'b0, lane_byte};
      3'b101:  load_data = {16'b0, lane_half};
      default: load_data = rword_q;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = (state_q == StResp) && err_q;
  assign rsp_rdata = ((state_q == StResp) && !we_q && !err_q) ? load_data : '0;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rword_d  = rword_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_err;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        rword_d = mem[mem_idx];
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rword_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rword_q  <= rword_d;
    end
  end

endmodule
